// File: rtl/hex_digit_scanner.sv
// hex_digit_scanner: time-multiplexes a 16-bit value onto one nibble bus and a
// one-hot digit-enable bus. A new value is captured into a shadow register and
// copied into the displayed value only at the 3->0 frame wrap. This means a
// single frame never mixes old and new digits.
//
// Ports:
//   clock       system clock, all state on the rising edge
//   reset       asynchronous, active-high reset
//   en          scan enable; 0 freezes idx/pcnt and blanks an
//   load_valid  a new display value is offered on load_data
//   load_data   four hex digits, [3:0] is digit 0 and [15:12] is digit 3
//   load_ready  high while no update is pending
//   c0..c3      bits 0..3 of the selected digit (combinational)
//   an          one-hot active-high digit enable (combinational)
//   wrap        registered one-cycle pulse after the scan wraps 3->0
module hex_digit_scanner #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic        c0,
  output logic        c1,
  output logic        c2,
  output logic        c3,
  output logic [3:0]  an,
  output logic        wrap
);

  localparam int unsigned VAL_W = 16;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  localparam logic [CNT_W-1:0] PCNT_LAST = CNT_W'(PRESCALE - 1);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [VAL_W-1:0] active;
  logic [VAL_W-1:0] shadow;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] pcnt;

  logic             tick;
  logic             last_slot;
  logic             accept;
  logic             apply;
  logic [3:0]       nibble;

  // End of a digit slot; last_slot marks the edge where idx goes 3 -> 0.
  assign tick      = en && (pcnt == PCNT_LAST);
  assign last_slot = tick && (idx == IDX_W'(3));

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    accept     = 1'b0;
    apply      = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          accept    = 1'b1;
          state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        // An accept that lands on a wrap edge waits for the next wrap.
        if (last_slot) begin
          apply     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Scan counters, value registers and the wrap pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active <= '0;
      shadow <= '0;
      idx    <= '0;
      pcnt   <= '0;
      wrap   <= 1'b0;
    end else begin
      if (en) begin
        pcnt <= tick ? '0 : pcnt + CNT_W'(1);
      end
      if (tick) begin
        idx <= idx + IDX_W'(1);
      end
      if (accept) begin
        shadow <= load_data;
      end
      if (apply) begin
        active <= shadow;
      end
      wrap <= last_slot;
    end
  end

  // Digit mux keeps tracking idx while blanked; only an is gated by en.
  assign nibble = active[{idx, 2'b00} +: 4];
  assign c0     = nibble[0];
  assign c1     = nibble[1];
  assign c2     = nibble[2];
  assign c3     = nibble[3];
  assign an     = en ? 4'(4'b0001 << idx) : 4'b0000;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Testbench for hex_digit_scanner (PRESCALE=4). A reference model counts
// enabled edges since reset. It pushes the expected outputs for each edge to a
// queue, and a negedge monitor pops each entry and compares it with the DUT.
// A vector table walks the main scan/load scenario with hand-derived end
// states, and hand sequences cover the wrap-edge load, the ignored second load
// and reset while an update is pending.
module tb_hex_digit_scanner;

  localparam int unsigned P = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0000;
  logic        load_ready;
  logic        c0, c1, c2, c3;
  logic [3:0]  an;
  logic        wrap;

  hex_digit_scanner #(.PRESCALE(P)) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .c0         (c0),
    .c1         (c1),
    .c2         (c2),
    .c3         (c3),
    .an         (an),
    .wrap       (wrap)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] c;
    logic       ready;
    logic       wrap;
  } obs_t;

  typedef struct {
    logic        en;
    logic        lv;
    logic [15:0] data;
    int          n;
    obs_t        exp;
  } vec_t;

  obs_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  int unsigned run = 0;
  logic [15:0] act_m = 16'h0000;
  logic [15:0] sh_m = 16'h0000;
  logic        pend_m = 1'b0;
  logic        wrap_m = 1'b0;

  function automatic obs_t mk_obs(logic [3:0] a, logic [3:0] c, logic r, logic w);
    obs_t o;
    o.an = a; o.c = c; o.ready = r; o.wrap = w;
    return o;
  endfunction

  function automatic vec_t mk_vec(logic e, logic lv, logic [15:0] d, int n, obs_t x);
    vec_t v;
    v.en = e; v.lv = lv; v.data = d; v.n = n; v.exp = x;
    return v;
  endfunction

  function automatic obs_t predict();
    int unsigned i;
    obs_t o;
    i = (run / P) % 4;
    o.an = en ? (4'b0001 << i) : 4'b0000;
    o.c = act_m[i*4 +: 4];
    o.ready = !pend_m;
    o.wrap = wrap_m;
    return o;
  endfunction

  function automatic obs_t observe();
    return mk_obs(an, {c3, c2, c1, c0}, load_ready, wrap);
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got an=%b c=%h ready=%b wrap=%b, expected an=%b c=%h ready=%b wrap=%b",
               name, got.an, got.c, got.ready, got.wrap, exp.an, exp.c, exp.ready, exp.wrap);
    end
  endtask

  task automatic model_reset();
    run = 0; act_m = 16'h0000; sh_m = 16'h0000; pend_m = 1'b0; wrap_m = 1'b0;
  endtask

  // One clock edge: drive inputs, advance the model, queue the expectation.
  task automatic step(input logic e, input logic lv, input logic [15:0] d);
    logic edge_wrap;
    logic acc;
    en = e; load_valid = lv; load_data = d;
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      edge_wrap = 1'b0;
      if (e) begin
        run++;
        edge_wrap = ((run % (4 * P)) == 0);
      end
      acc = lv && !pend_m;
      if (pend_m && edge_wrap) begin
        act_m = sh_m;
        pend_m = 1'b0;
      end
      if (acc) begin
        sh_m = d;
        pend_m = 1'b1;
      end
      wrap_m = edge_wrap;
    end
    sbq.push_back(predict());
    @(negedge clock);
    #1;
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clock) begin
    if (sbq.size() > 0) begin
      obs_t e;
      e = sbq.pop_front();
      check("scoreboard", observe(), e);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl[$];

  initial begin
    // Scan walk, mid-frame load and a freeze at idx=2.
    tbl.push_back(mk_vec(1'b1, 1'b0, 16'h0000, 3,  mk_obs(4'b0001, 4'h0, 1'b1, 1'b0)));
    tbl.push_back(mk_vec(1'b1, 1'b0, 16'h0000, 1,  mk_obs(4'b0010, 4'h0, 1'b1, 1'b0)));
    tbl.push_back(mk_vec(1'b1, 1'b0, 16'h0000, 12, mk_obs(4'b0001, 4'h0, 1'b1, 1'b1)));
    tbl.push_back(mk_vec(1'b1, 1'b1, 16'hA5C3, 1,  mk_obs(4'b0001, 4'h0, 1'b0, 1'b0)));
    tbl.push_back(mk_vec(1'b1, 1'b0, 16'h0000, 14, mk_obs(4'b1000, 4'h0, 1'b0, 1'b0)));
    tbl.push_back(mk_vec(1'b1, 1'b0, 16'h0000, 1,  mk_obs(4'b0001, 4'h3, 1'b1, 1'b1)));
    tbl.push_back(mk_vec(1'b1, 1'b0, 16'h0000, 4,  mk_obs(4'b0010, 4'hC, 1'b1, 1'b0)));
    tbl.push_back(mk_vec(1'b1, 1'b0, 16'h0000, 2,  mk_obs(4'b0010, 4'hC, 1'b1, 1'b0)));
    tbl.push_back(mk_vec(1'b1, 1'b0, 16'h0000, 2,  mk_obs(4'b0100, 4'h5, 1'b1, 1'b0)));
    tbl.push_back(mk_vec(1'b0, 1'b0, 16'h0000, 10, mk_obs(4'b0000, 4'h5, 1'b1, 1'b0)));
    tbl.push_back(mk_vec(1'b1, 1'b0, 16'h0000, 2,  mk_obs(4'b0100, 4'h5, 1'b1, 1'b0)));
    tbl.push_back(mk_vec(1'b1, 1'b0, 16'h0000, 2,  mk_obs(4'b1000, 4'hA, 1'b1, 1'b0)));
    tbl.push_back(mk_vec(1'b1, 1'b0, 16'h0000, 4,  mk_obs(4'b0001, 4'h3, 1'b1, 1'b1)));

    // Reset state, checked while reset is held.
    en = 1'b1;
    #2;
    check("reset_en1", observe(), mk_obs(4'b0001, 4'h0, 1'b1, 1'b0));
    en = 1'b0;
    #1;
    check("reset_en0", observe(), mk_obs(4'b0000, 4'h0, 1'b1, 1'b0));
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 16'hFFFF);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(tbl[i].en, (k == 0) ? tbl[i].lv : 1'b0, tbl[i].data);
      end
      check($sformatf("vec%0d", i), observe(), tbl[i].exp);
    end

    // Load offered on the wrap edge applies at the following wrap;
    // a second load while pending is ignored.
    repeat (15) step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 16'h7E91);
    check("wrap_edge_accept", observe(), mk_obs(4'b0001, 4'h3, 1'b0, 1'b1));
    repeat (15) step(1'b1, 1'b1, 16'h1234);
    check("pending_old_digit3", observe(), mk_obs(4'b1000, 4'hA, 1'b0, 1'b0));
    step(1'b1, 1'b0, 16'h0000);
    check("applied_next_wrap", observe(), mk_obs(4'b0001, 4'h1, 1'b1, 1'b1));
    repeat (12) step(1'b1, 1'b0, 16'h0000);
    check("applied_digit3", observe(), mk_obs(4'b1000, 4'h7, 1'b1, 1'b0));

    // Reset while an update is pending discards it.
    step(1'b1, 1'b1, 16'hBEEF);
    repeat (5) step(1'b1, 1'b0, 16'h0000);
    reset = 1'b1;
    model_reset();
    #1;
    check("reset_in_pending", observe(), mk_obs(4'b0001, 4'h0, 1'b1, 1'b0));
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    reset = 1'b0;
    repeat (40) step(1'b1, 1'b0, 16'h0000);
    check("after_reset_run", observe(), mk_obs(4'b0100, 4'h0, 1'b1, 1'b0));

    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
